pipe_seg_skid: RTL and testbench

Parametrised successor to the fixed MEM/WB segment register. It carries an arbitrary packed payload between two pipeline stages using a valid/ready handshake. A 2-entry skid buffer keeps in_ready registered, so there is no combinational path from out_ready to in_ready. It also adds synchronous flush, bubble insertion, occupancy reporting and a saturating downstream-stall counter; a generic segment register for IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_seg_skid_pkg.sv | 34 +++
 rtl/pipe_seg_skid_if.sv | 11 +
 rtl/pipe_seg_skid_sat_counter.sv | 28 ++
 rtl/pipe_seg_skid.sv | 103 ++++++++++
 tb/tb_pipe_seg_skid.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/pipe_seg_skid_pkg.sv
// Shared types and constants for the generic pipeline segment register.
// Holds the segment state encoding and the MEM/WB bundle field layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } seg_state_e;

  localparam int IFID_W  = 64;
  localparam int IDEX_W  = 147;
  localparam int EXMEM_W = 137;
  localparam int MEMWB_W = 137;

  // MEM/WB bundle, rd at the bottom and pc at the top.
  localparam int RD_LSB     = 0;
  localparam int NWE_BIT    = 5;
  localparam int WSEL_LSB   = 6;
  localparam int RDATA1_LSB = 9;
  localparam int RAM_LSB    = 41;
  localparam int ALU_LSB    = 73;
  localparam int PC_LSB     = 105;

  function automatic logic [1:0] occ_of(input seg_state_e s);
    case (s)
      EMPTY:   occ_of = 2'd0;
      ONE:     occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_seg_skid_if.sv
// Valid/ready payload channel between two pipeline stages.
interface pipe_seg_skid_if #(
  parameter int DATA_W = 137
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_seg_skid_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_seg_skid.sv
// Generic pipeline segment register with a 2-entry skid buffer, flush,
// occupancy report and a saturating downstream-stall counter.
module pipe_seg_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W = MEMWB_W,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int                CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  cnt_clr,
  pipe_seg_skid_if.slave        in_if,
  pipe_seg_skid_if.master       out_if,
  output logic [1:0]            occupancy,
  output logic [CNT_W-1:0]      stall_cnt
);

  seg_state_e        r_state, w_state_nxt;
  logic [DATA_W-1:0] r_main, w_main_nxt;
  logic [DATA_W-1:0] r_skid, w_skid_nxt;
  logic              w_push, w_pop;

  // Handshake outputs decode the state register only, so in_ready never
  // depends combinationally on out_ready.
  assign out_if.valid = (r_state != EMPTY);
  assign in_if.ready  = (r_state != FULL);
  assign out_if.data  = r_main;
  assign occupancy    = occ_of(r_state);

  assign w_push = in_if.valid & in_if.ready;
  assign w_pop  = out_if.valid & out_if.ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= EMPTY;
      r_main  <= BUBBLE;
      r_skid  <= BUBBLE;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = BUBBLE;
      w_skid_nxt  = BUBBLE;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_state_nxt = ONE;
            w_main_nxt  = in_if.data;
          end
        end
        ONE: begin
          case ({w_push, w_pop})
            2'b11: w_main_nxt = in_if.data;
            2'b10: begin
              w_state_nxt = FULL;
              w_skid_nxt  = in_if.data;
            end
            2'b01: begin
              w_state_nxt = EMPTY;
              w_main_nxt  = BUBBLE;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (w_pop) begin
            w_state_nxt = ONE;
            w_main_nxt  = r_skid;
            w_skid_nxt  = BUBBLE;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_main_nxt  = BUBBLE;
          w_skid_nxt  = BUBBLE;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (resetn),
    .i_inc (out_if.valid & ~out_if.ready),
    .i_clr (cnt_clr),
    .o_cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_seg_skid.sv
// Directed bench for pipe_seg_skid: reset, streaming, backpressure, flush,
// stall counter saturation/clear and asynchronous reset while full.
module tb_pipe_seg_skid;

  localparam int DW = 137;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic          cnt_clr;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_seg_skid_if #(.DATA_W(DW)) in_if ();
  pipe_seg_skid_if #(.DATA_W(DW)) out_if ();

  pipe_seg_skid #(
    .DATA_W (DW),
    .BUBBLE ('0),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .in_if     (in_if),
    .out_if    (out_if),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_if.valid); end
    checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_if.ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (out_if.data !== '0) begin errors++; $display("FAIL reset_data got=%0h exp=0", out_if.data); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp_d;
    out_if.ready = 1'b1;
    in_if.valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_d = DW'(i);
      in_if.data = exp_d;
      tick();
      checks++; if (out_if.data !== exp_d) begin errors++; $display("FAIL stream_data%0d got=%0h exp=%0h", i, out_if.data, exp_d); end
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ%0d got=%0d exp=1", i, occupancy); end
      checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready%0d got=%0b exp=1", i, in_if.ready); end
    end
    in_if.valid = 1'b0;
    tick();
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got=%0b exp=0", out_if.valid); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL stream_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_fill();
    out_if.ready = 1'b0;
    in_if.valid = 1'b1; in_if.data = DW'(32'hA);
    tick();
    in_if.data = DW'(32'hB);
    tick();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL fill_occ got=%0d exp=2", occupancy); end
    checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%0b exp=0", in_if.ready); end
    in_if.data = DW'(32'hC);
    tick();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL fill_ignore_occ got=%0d exp=2", occupancy); end
    checks++; if (out_if.data !== DW'(32'hA)) begin errors++; $display("FAIL fill_hold got=%0h exp=a", out_if.data); end
    checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL fill_stall got=%0d exp=2", stall_cnt); end
    in_if.valid = 1'b0; out_if.ready = 1'b1;
    tick();
    checks++; if (out_if.data !== DW'(32'hB)) begin errors++; $display("FAIL fill_pop_b got=%0h exp=b", out_if.data); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL fill_pop_occ got=%0d exp=1", occupancy); end
    tick();
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL fill_empty got=%0b exp=0", out_if.valid); end
    checks++; if (out_if.data !== '0) begin errors++; $display("FAIL fill_bubble got=%0h exp=0", out_if.data); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL fill_clr got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_flush();
    out_if.ready = 1'b0;
    in_if.valid = 1'b1; in_if.data = DW'(32'hA);
    tick();
    in_if.data = DW'(32'hB);
    tick();
    in_if.data = DW'(32'hD); flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", out_if.valid); end
    checks++; if (out_if.data !== '0) begin errors++; $display("FAIL flush_data got=%0h exp=0", out_if.data); end
    checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%0b exp=1", in_if.ready); end
    in_if.valid = 1'b0;
    tick();
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL flush_no_d got=%0b exp=0", out_if.valid); end
    checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL flush_keeps_cnt got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_sat();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    out_if.ready = 1'b0;
    in_if.valid = 1'b1; in_if.data = DW'(32'h7);
    tick();
    in_if.valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_value got=%0d exp=15", stall_cnt); end
    checks++; if (out_if.data !== DW'(32'h7)) begin errors++; $display("FAIL sat_stable got=%0h exp=7", out_if.data); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL sat_clr got=%0d exp=0", stall_cnt); end
    tick(); tick();
    checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL sat_resume got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_async_reset();
    in_if.valid = 1'b1; in_if.data = DW'(32'h8);
    tick();
    in_if.valid = 1'b0;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL areset_pre_occ got=%0d exp=2", occupancy); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%0b exp=0", out_if.valid); end
    checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got=%0b exp=1", in_if.ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL areset_occ got=%0d exp=0", occupancy); end
    checks++; if (out_if.data !== '0) begin errors++; $display("FAIL areset_data got=%0h exp=0", out_if.data); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL areset_stall got=%0d exp=0", stall_cnt); end
    tick();
    resetn = 1'b1;
    out_if.ready = 1'b1;
    in_if.valid = 1'b1; in_if.data = DW'(32'h5);
    tick();
    in_if.valid = 1'b0;
    checks++; if (out_if.data !== DW'(32'h5)) begin errors++; $display("FAIL areset_first_push got=%0h exp=5", out_if.data); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL areset_first_occ got=%0d exp=1", occupancy); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_flush();
    test_sat();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
